// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, reset
// defaults, control-decoder encodings and PC helper functions.
package ifu_pkg;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC      = 32'h0000_3000;
    localparam int          DEFAULT_FETCH_TIMEOUT = 16;

    // Opcode and funct encodings seen by the control decoder via OP/funct.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2
    } npc_sel_t;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection: jump beats taken branch, which beats the sequential path.
module npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] index,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] next_pc
);

    npc_sel_t sel;

    always_comb begin
        sel = NPC_SEQ;
        if (!Jump)
            sel = NPC_JUMP;
        else if (Branch && Zero)
            sel = NPC_BRANCH;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            NPC_JUMP:   next_pc = jump_target(pc_plus4, index);
            NPC_BRANCH: next_pc = pc_plus4 + branch_offset(index[15:0]);
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: FETCH/EXEC/HALT sequencer owning the PC, the
// instruction register and the fetch-timeout watchdog.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int          FETCH_TIMEOUT = DEFAULT_FETCH_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    logic [1:0]       state;
    logic [31:0]      pc_reg;
    logic [31:0]      ir;
    logic [CNT_W-1:0] timeout_cnt;
    logic             err_reg;
    logic [31:0]      next_pc;

    assign pc_plus4 = pc_reg + 32'd4;

    npc u_npc (
        .pc_plus4 (pc_plus4),
        .index    (ir[25:0]),
        .Branch   (Branch),
        .Zero     (Zero),
        .Jump     (Jump),
        .next_pc  (next_pc)
    );

    // An ack on the last allowed FETCH cycle still wins over the timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc_reg      <= RESET_PC;
            ir          <= 32'd0;
            timeout_cnt <= '0;
            err_reg     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_EXEC;
                    end else if (timeout_cnt == CNT_LAST) begin
                        state   <= ST_HALT;
                        err_reg <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_reg      <= next_pc;
                        timeout_cnt <= '0;
                        state       <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req    = (state == ST_FETCH);
    assign instr_valid = (state == ST_EXEC);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = ir;
    assign OP          = ir[31:26];
    assign funct       = ir[5:0];
    assign fetch_err   = err_reg;

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded by reset.
REQ-002 Parameter FETCH_TIMEOUT, default 16: maximum FETCH cycles without imem_ack before the fault halt.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of the fetch; always equals pc.
REQ-007 imem_ack  input  1  memory response; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  instruction register (IR).
REQ-010 OP  output  6  instr[31:26], to the control decoder.
REQ-011 funct  output  6  instr[5:0], to the control decoder.
REQ-012 instr_valid  output  1  high while IR holds the instruction being executed.
REQ-013 stall  input  1  holds the current instruction in EXEC.
REQ-014 Branch  input  1  conditional branch request from the control decoder.
REQ-015 Zero  input  1  ALU zero flag.
REQ-016 Jump  input  1  active-low; 0 selects the jump target.
REQ-017 pc  output  32  address of the instruction in IR or being fetched.
REQ-018 pc_plus4  output  32  pc+4 (link value).
REQ-019 fetch_err  output  1  sticky fetch-timeout fault flag.

Function
REQ-020 States SHALL be FETCH, EXEC and HALT, with transitions only as listed below.
REQ-021 In FETCH, imem_req SHALL be 1 and instr_valid 0; on imem_ack, IR SHALL load imem_rdata and the state SHALL become EXEC next cycle.
REQ-022 In EXEC, imem_req SHALL be 0, instr_valid 1, and IR and pc held stable.
REQ-023 In EXEC with stall=0, pc SHALL load npc and the state SHALL return to FETCH; with stall=1, the block SHALL stay in EXEC with nothing changing.
REQ-024 Minimum throughput SHALL be 2 cycles per instruction: ack in the first FETCH cycle, then one EXEC cycle.
REQ-025 npc priority: Jump=0 gives {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch&Zero gives pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000); negative offsets SHALL sign-extend.
REQ-027 Jump, Branch and Zero SHALL be sampled only on the EXEC cycle with stall=0 and ignored otherwise.
REQ-028 A timeout counter SHALL clear on entry to FETCH and increment each FETCH cycle without ack.
REQ-029 If FETCH_TIMEOUT consecutive FETCH cycles pass with no ack, the state SHALL become HALT and fetch_err SHALL be set to 1.
REQ-030 An ack in the same cycle the counter reaches the limit SHALL take priority: the fetch completes and no fault occurs.
REQ-031 In HALT, imem_req=0 and instr_valid=0; only reset SHALL exit HALT.
REQ-032 imem_ack outside FETCH SHALL be ignored: IR is not loaded and no state change occurs.
REQ-033 pc_plus4 SHALL be combinational from pc; OP and funct SHALL be combinational from IR.

Reset
REQ-034 A reset sampled high SHALL, from any state including mid-fetch, EXEC with stall, or HALT, produce next cycle: state FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=1, fetch_err=0, counter=0.
REQ-035 An imem_ack arriving in the same cycle as reset SHALL be discarded.

Structure
REQ-036 The state encodings, the RESET_PC default and the FETCH_TIMEOUT default SHALL live in the shared define file alongside the control encodings.
REQ-037 The next-PC computation SHALL be one combinational sub-module, npc, instantiated once; the FSM, PC, IR and counter SHALL stay in ifu.

Verification
REQ-038 Reset, then ack on the first FETCH cycle with rdata=0x3402_0005, Jump=1, Branch=0 -> instr_valid in cycle 2, pc 0x3000 then 0x3004, OP=0x0D.
REQ-039 EXEC at pc=0x3010 with instr[15:0]=0xFFFE, Branch=1, Zero=1, Jump=1 -> next pc 0x300C; same case with Zero=0 -> next pc 0x3014.
REQ-040 EXEC at pc=0x3000 with instr=0x0C00_0C08, Jump=0, Branch=1, Zero=1 -> next pc 0x0000_3020 (jump wins over branch).
REQ-041 stall=1 for 3 EXEC cycles -> pc, instr and instr_valid constant; stall then drops -> pc advances exactly once.
REQ-042 No ack for 16 FETCH cycles -> HALT, fetch_err=1, imem_req=0; a later ack is ignored; reset -> pc=0x3000, fetch_err=0; ack on the 16th cycle instead -> normal EXEC.
REQ-043 pc=0xFFFF_FFFC with a sequential instruction -> next pc 0x0000_0000.
